// File: rtl/hilo_mac_sequencer.sv
// hilo_mac_sequencer
//   Multi-cycle 32x32 multiply / multiply-accumulate unit with architectural
//   HI/LO registers. It uses a radix-2 shift-add on operand magnitudes over
//   32 cycles, followed by one accumulate/writeback cycle.
//
//   Ports
//     Clk        : clock; all state changes on the rising edge
//     Reset      : synchronous active-high reset
//     Start      : begin the operation selected by ALUOp
//     ALUOp[4:0] : 26 multu, 29 MSUB, 30 MADD, 31 mul (others ignored)
//     A, B       : operands, sampled on the accepting edge
//     MthiEn     : load HI from A when idle
//     MtloEn     : load LO from A when idle
//     Flush      : abort any in-flight operation
//     Stall      : pipeline hold request (combinational)
//     Done       : one-cycle completion pulse
//     MulResult  : low word of the last completed mul
//     HI, LO     : architectural HI/LO registers
module hilo_mac_sequencer (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [4:0]  ALUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MthiEn,
  input  logic        MtloEn,
  input  logic        Flush,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] MulResult,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] OP_MULTU = 5'd26;
  localparam logic [4:0] OP_MSUB  = 5'd29;
  localparam logic [4:0] OP_MADD  = 5'd30;
  localparam logic [4:0] OP_MUL   = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [4:0]  r_op;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_prod;
  logic        r_neg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_mulres;

  logic        w_supported;
  logic        w_idle_like;
  logic        w_accept;
  logic        w_signed_in;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [63:0] w_p;
  logic [63:0] w_acc;
  logic [63:0] w_sum;
  logic [63:0] w_diff;

  always_comb begin
    w_supported = 1'b0;
    case (ALUOp)
      OP_MULTU, OP_MSUB, OP_MADD, OP_MUL: w_supported = 1'b1;
      default:                            w_supported = 1'b0;
    endcase
  end

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  // Flush does not gate the accept here: it only blocks the register
  // updates below, so Stall still reflects a supported Start request.
  assign w_accept    = w_idle_like && Start && w_supported;

  assign w_signed_in = (ALUOp != OP_MULTU);
  assign w_mag_a     = (w_signed_in && A[31]) ? (~A + 32'd1) : A;
  assign w_mag_b     = (w_signed_in && B[31]) ? (~B + 32'd1) : B;

  // Sign is re-applied to the full 64-bit magnitude product only at writeback.
  assign w_p    = r_neg ? (~r_prod + 64'd1) : r_prod;
  assign w_acc  = {r_hi, r_lo};
  assign w_sum  = w_acc + w_p;
  assign w_diff = w_acc - w_p;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_CALC : S_IDLE;
      S_CALC:  w_next = (r_cnt == 5'd31) ? S_ACCUM : S_CALC;
      S_ACCUM: w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (Flush) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mulres <= '0;
    end else if (!Flush) begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_op     <= ALUOp;
        r_mcand  <= {32'd0, w_mag_a};
        r_mplier <= w_mag_b;
        r_prod   <= '0;
        r_neg    <= w_signed_in && (A[31] ^ B[31]);
      end else if (w_idle_like) begin
        if (MthiEn) r_hi <= A;
        if (MtloEn) r_lo <= A;
      end

      if (r_state == S_CALC) begin
        if (r_mplier[0]) begin
          r_prod <= r_prod + r_mcand;
        end
        r_mcand  <= {r_mcand[62:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[31:1]};
        r_cnt    <= r_cnt + 5'd1;
      end

      if (r_state == S_ACCUM) begin
        case (r_op)
          OP_MULTU: begin
            r_hi <= w_p[63:32];
            r_lo <= w_p[31:0];
          end
          OP_MADD: begin
            r_hi <= w_sum[63:32];
            r_lo <= w_sum[31:0];
          end
          OP_MSUB: begin
            r_hi <= w_diff[63:32];
            r_lo <= w_diff[31:0];
          end
          OP_MUL: begin
            r_mulres <= w_p[31:0];
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign Stall     = w_accept || (r_state == S_CALC) || (r_state == S_ACCUM);
  assign Done      = (r_state == S_DONE);
  assign MulResult = r_mulres;
  assign HI        = r_hi;
  assign LO        = r_lo;

endmodule

// File: tb/tb_hilo_mac_sequencer.sv
module tb_hilo_mac_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [4:0]  ALUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        MthiEn;
  logic        MtloEn;
  logic        Flush;
  logic        Stall;
  logic        Done;
  logic [31:0] MulResult;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  hilo_mac_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .ALUOp     (ALUOp),
    .A         (A),
    .B         (B),
    .MthiEn    (MthiEn),
    .MtloEn    (MtloEn),
    .Flush     (Flush),
    .Stall     (Stall),
    .Done      (Done),
    .MulResult (MulResult),
    .HI        (HI),
    .LO        (LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue Start, then wait (bounded) for Done. lat counts edges after the
  // accepting edge until Done is seen; stl counts Stall-high cycles in that window.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stl);
    Start = 1'b1; ALUOp = op; A = a; B = b;
    #1;
    chk("stall_on_accept", {63'd0, Stall}, 64'd1);
    @(posedge Clk);
    #1;
    Start = 1'b0; A = '0; B = '0;
    lat = 0;
    stl = 0;
    while (!Done && lat < 40) begin
      if (Stall) stl++;
      tick();
      lat++;
    end
  endtask

  int lat;
  int stl;
  int cnt_done;
  int cnt_stall;

  initial begin
    Reset = 1'b1; Start = 1'b0; ALUOp = '0; A = '0; B = '0;
    MthiEn = 1'b0; MtloEn = 1'b0; Flush = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_hi",    {32'd0, HI}, 64'd0);
    chk("rst_lo",    {32'd0, LO}, 64'd0);
    chk("rst_mulres",{32'd0, MulResult}, 64'd0);
    chk("rst_done",  {63'd0, Done}, 64'd0);
    chk("rst_stall", {63'd0, Stall}, 64'd0);
    tick();

    // multu 0xFFFFFFFF * 0xFFFFFFFF
    run_op(5'd26, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stl);
    chk("multu_latency", 64'(lat), 64'd33);
    chk("multu_stall_cycles", 64'(stl), 64'd33);
    chk("multu_done", {63'd0, Done}, 64'd1);
    chk("multu_hi", {32'd0, HI}, 64'hFFFF_FFFE);
    chk("multu_lo", {32'd0, LO}, 64'h0000_0001);
    tick();
    chk("multu_done_pulse", {63'd0, Done}, 64'd0);
    chk("multu_idle_stall", {63'd0, Stall}, 64'd0);

    // Mthi / Mtlo then MADD 1*1
    MthiEn = 1'b1; A = 32'h0;
    tick();
    MthiEn = 1'b0; MtloEn = 1'b1; A = 32'hFFFF_FFFF;
    tick();
    MtloEn = 1'b0; A = '0;
    chk("mthi_hi", {32'd0, HI}, 64'h0);
    chk("mtlo_lo", {32'd0, LO}, 64'hFFFF_FFFF);
    run_op(5'd30, 32'd1, 32'd1, lat, stl);
    chk("madd_carry_lat", 64'(lat), 64'd33);
    chk("madd_carry_hi", {32'd0, HI}, 64'h1);
    chk("madd_carry_lo", {32'd0, LO}, 64'h0);
    tick();

    // Both enables load both registers
    MthiEn = 1'b1; MtloEn = 1'b1; A = 32'h0;
    tick();
    MthiEn = 1'b0; MtloEn = 1'b0;
    chk("mthilo_hi", {32'd0, HI}, 64'h0);
    chk("mthilo_lo", {32'd0, LO}, 64'h0);

    // MSUB 2*3 from zero, then MADD -3*2
    run_op(5'd29, 32'd2, 32'd3, lat, stl);
    chk("msub_hi", {32'd0, HI}, 64'hFFFF_FFFF);
    chk("msub_lo", {32'd0, LO}, 64'hFFFF_FFFA);
    tick();
    run_op(5'd30, 32'hFFFF_FFFD, 32'd2, lat, stl);
    chk("madd_neg_hi", {32'd0, HI}, 64'hFFFF_FFFF);
    chk("madd_neg_lo", {32'd0, LO}, 64'hFFFF_FFF4);
    tick();

    // mul -3*7, then back-to-back mul 5*6 started in DONE
    run_op(5'd31, 32'hFFFF_FFFD, 32'd7, lat, stl);
    chk("mul_done", {63'd0, Done}, 64'd1);
    chk("mul_result", {32'd0, MulResult}, 64'hFFFF_FFEB);
    chk("mul_hi_keep", {32'd0, HI}, 64'hFFFF_FFFF);
    chk("mul_lo_keep", {32'd0, LO}, 64'hFFFF_FFF4);
    run_op(5'd31, 32'd5, 32'd6, lat, stl);
    chk("b2b_latency", 64'(lat), 64'd33);
    chk("b2b_stall_cycles", 64'(stl), 64'd33);
    chk("b2b_result", {32'd0, MulResult}, 64'h1E);
    tick();

    // Flush 10 cycles into multu; an Mtlo during CALC must be ignored
    Start = 1'b1; ALUOp = 5'd26; A = 32'd123; B = 32'd456;
    tick();
    Start = 1'b0; A = '0; B = '0;
    repeat (4) tick();
    MtloEn = 1'b1; A = 32'h1234;
    tick();
    MtloEn = 1'b0; A = '0;
    repeat (5) tick();
    chk("pre_flush_stall", {63'd0, Stall}, 64'd1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_stall", {63'd0, Stall}, 64'd0);
    chk("flush_done", {63'd0, Done}, 64'd0);
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) cnt_done++;
      tick();
    end
    chk("flush_no_done", 64'(cnt_done), 64'd0);
    chk("flush_hi", {32'd0, HI}, 64'hFFFF_FFFF);
    chk("flush_lo", {32'd0, LO}, 64'hFFFF_FFF4);

    // Flush in ACCUM suppresses the write
    Start = 1'b1; ALUOp = 5'd30; A = 32'd1; B = 32'd1;
    tick();
    Start = 1'b0; A = '0; B = '0;
    repeat (32) tick();
    chk("accum_stall", {63'd0, Stall}, 64'd1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("accum_flush_done", {63'd0, Done}, 64'd0);
    chk("accum_flush_stall", {63'd0, Stall}, 64'd0);
    chk("accum_flush_hi", {32'd0, HI}, 64'hFFFF_FFFF);
    chk("accum_flush_lo", {32'd0, LO}, 64'hFFFF_FFF4);
    chk("accum_flush_mulres", {32'd0, MulResult}, 64'h1E);
    tick();

    // Reset at cycle 20 of MADD
    Start = 1'b1; ALUOp = 5'd30; A = 32'd3; B = 32'd4;
    tick();
    Start = 1'b0; A = '0; B = '0;
    repeat (19) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_hi", {32'd0, HI}, 64'h0);
    chk("midrst_lo", {32'd0, LO}, 64'h0);
    chk("midrst_mulres", {32'd0, MulResult}, 64'h0);
    chk("midrst_done", {63'd0, Done}, 64'd0);
    chk("midrst_stall", {63'd0, Stall}, 64'd0);
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) cnt_done++;
      tick();
    end
    chk("midrst_no_done", 64'(cnt_done), 64'd0);
    chk("midrst_hi_later", {32'd0, HI}, 64'h0);

    // Unsupported op 2 with Start held
    Start = 1'b1; ALUOp = 5'd2; A = 32'd7; B = 32'd7;
    #1;
    chk("unsup_stall", {63'd0, Stall}, 64'd0);
    cnt_done = 0;
    cnt_stall = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done) cnt_done++;
      if (Stall) cnt_stall++;
    end
    Start = 1'b0;
    chk("unsup_no_done", 64'(cnt_done), 64'd0);
    chk("unsup_no_stall", 64'(cnt_stall), 64'd0);
    chk("unsup_hi", {32'd0, HI}, 64'h0);
    chk("unsup_lo", {32'd0, LO}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
